fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter WORDSIZE, default 8, width of each requester data word and of the FIFO write port.
REQ-002 Parameter BURST, default 4, legal range 1..15, maximum words accepted per grant before forced rotation.
REQ-003 wclk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  per-requester write request; bit i belongs to requester i.
REQ-006 req_data  input  4*WORDSIZE  requester i data on bits [i*WORDSIZE +: WORDSIZE].
REQ-007 full  input  1  FIFO full flag, write-clock domain.
REQ-008 signal_write  output  1  FIFO write strobe.
REQ-009 write_data  output  WORDSIZE  FIFO write word.
REQ-010 grant  output  4  one-hot current owner, all-zero when idle.
REQ-011 ack  output  4  per-requester pulse: word accepted on this edge.

Function
REQ-012 The block SHALL implement two states, IDLE (grant=0) and BUSY (grant one-hot, registered).
REQ-013 IDLE: if req!=0 at a rising edge, SHALL enter BUSY granting the first requester with req set, searching round-robin from (last+1) mod 4, where last is the most recently granted index.
REQ-014 The block SHALL update last to the new grant index on every IDLE->BUSY transition.
REQ-015 BUSY, owner g: signal_write SHALL be combinational = req[g] & ~full.
REQ-016 write_data SHALL be combinational = req_data slice g while BUSY; all-zero in IDLE.
REQ-017 ack[g] SHALL equal signal_write; all other ack bits 0; requester advances its data on the acking edge.
REQ-018 A burst counter (4 bits) SHALL clear on entry to BUSY and increment on each edge with signal_write=1.
REQ-019 BUSY SHALL return to IDLE at the edge where a write occurs and the counter equals BURST-1 (BURST words written).
REQ-020 BUSY SHALL return to IDLE at any edge where req[g]=0 (owner withdrew); no write occurs that cycle.
REQ-021 full=1 with req[g]=1 SHALL hold BUSY, no write, counter unchanged, grant unchanged (stall, no timeout).
REQ-022 Latency: req asserted before edge n from IDLE -> grant valid after edge n -> first write possible on edge n+1.
REQ-023 Each grant change passes through exactly one IDLE cycle; no requester SHALL be granted twice in a row while another requester holds req=1 at the IDLE edge.
REQ-024 Requests from non-owners SHALL be ignored while BUSY (no preemption).
REQ-025 At most one bit of grant and of ack SHALL be 1 at any time.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, grant=0, counter=0, last=3 (requester 0 first priority), hence signal_write=0, ack=0, write_data=0 without waiting for wclk.
REQ-027 Reset asserted mid-burst SHALL drop the burst; words not acked are not written and are not counted.
REQ-028 First arbitration after rst deassertion SHALL occur on the first rising edge with rst=0.

Verification
REQ-029 Reset, req=4'b0001, data0=8'hA5, full=0 -> grant=0001 after edge 1; 4 writes of A5 with ack[0] on edges 2..5; IDLE after edge 5.
REQ-030 req=4'b1111 held, BURST=4, full=0 -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001; 4 writes per owner.
REQ-031 Owner 1 granted, full=1 for 3 cycles after first write -> no signal_write, grant holds, counter=1; full=0 -> remaining 3 words written, total 4.
REQ-032 Owner 2 granted, req[2] drops after 2 writes -> IDLE next edge, counter cleared; req=4'b0101 -> next grant 0001 (search from 3).
REQ-033 rst pulsed asynchronously between edges during a burst (owner 3) -> grant, signal_write, ack go 0 before next edge; after release, req=1111 -> grant 0001.
REQ-034 Random req/full, 10k cycles -> grant and ack one-hot-or-zero, signal_write only when ~full, no burst exceeds BURST words, every continuously requesting input granted within 4 grant periods.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle between four requesters, the arbiter and a FIFO write port.
// The arbiter takes the slave view; whoever drives requests and full takes master.
interface fifo_write_arbiter_if #(
    parameter int unsigned WORDSIZE = 8
);
    logic [3:0]            req;
    logic [4*WORDSIZE-1:0] req_data;
    logic                  full;
    logic                  signal_write;
    logic [WORDSIZE-1:0]   write_data;
    logic [3:0]            grant;
    logic [3:0]            ack;

    modport master (
        output req, req_data, full,
        input  signal_write, write_data, grant, ack
    );

    modport slave (
        input  req, req_data, full,
        output signal_write, write_data, grant, ack
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that lets four requesters share one FIFO write port.
// An owner keeps the port for at most BURST words; every hand-over passes through IDLE.
module fifo_write_arbiter #(
    parameter int unsigned WORDSIZE = 8,
    parameter int unsigned BURST    = 4
) (
    input logic                  wclk,
    input logic                  rst,
    fifo_write_arbiter_if.slave  bus
);
    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]   last_q,  last_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [WORDSIZE-1:0] words [NREQ];
    logic                busy;
    logic                owner_req;
    logic                write_c;
    logic [IDX_W-1:0]    pick;
    logic                found;
    logic [IDX_W-1:0]    cand;

    // last_q doubles as the owner index while BUSY, since it is loaded on every grant
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            words[i] = bus.req_data[i*WORDSIZE +: WORDSIZE];
        end
    end

    assign busy      = (state_q == BUSY);
    assign owner_req = bus.req[last_q];
    assign write_c   = busy & owner_req & ~bus.full;

    assign bus.signal_write = write_c;
    assign bus.write_data   = busy ? words[last_q] : '0;
    assign bus.ack          = write_c ? (4'b0001 << last_q) : 4'b0000;
    assign bus.grant        = grant_q;

    // Round-robin search starting just after the most recent grant
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDX_W'(last_q + IDX_W'(k));
            if (!found && bus.req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    grant_d = 4'b0001 << pick;
                    last_d  = pick;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (!bus.full) begin
                    if (cnt_q == BURST_LAST) begin
                        state_d = IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios with literal
// expectations plus a long randomized run against a transaction-level model.
module tb_fifo_write_arbiter;
    localparam int unsigned W = 8;
    localparam int unsigned B = 4;

    logic wclk = 1'b0;
    logic rst  = 1'b0;
    always #5 wclk = ~wclk;

    logic [3:0]   req_v;
    logic         full_v;
    logic [W-1:0] rdata [4];

    fifo_write_arbiter_if #(.WORDSIZE(W)) bus ();

    assign bus.req      = req_v;
    assign bus.full     = full_v;
    assign bus.req_data = {rdata[3], rdata[2], rdata[1], rdata[0]};

    fifo_write_arbiter #(.WORDSIZE(W), .BURST(B)) dut (
        .wclk (wclk),
        .rst  (rst),
        .bus  (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_owner = -1;
    int          m_last  = 3;
    int          m_cnt   = 0;
    logic [3:0]  adv;
    logic [3:0]  req_at_edge;
    int          waits  [4];
    int          ackcnt [4];
    bit          chk_en = 0;
    bit          adv_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: who owns the port and how many words it has written
    always @(posedge wclk or posedge rst) begin
        adv = 4'b0000;
        if (rst) begin
            m_owner = -1;
            m_last  = 3;
            m_cnt   = 0;
        end else begin
            req_at_edge = req_v;
            for (int i = 0; i < 4; i++) if (!req_v[i]) waits[i] = 0;
            if (m_owner < 0) begin
                if (req_v != 4'b0000) begin
                    bit got;
                    got = 0;
                    for (int k = 1; k <= 4; k++) begin
                        int c;
                        c = (m_last + k) % 4;
                        if (!got && req_v[c]) begin
                            m_owner = c;
                            got = 1;
                        end
                    end
                    m_last = m_owner;
                    m_cnt  = 0;
                end
            end else if (!req_v[m_owner]) begin
                m_owner = -1;
            end else if (!full_v) begin
                m_cnt++;
                adv[m_owner] = 1'b1;
                if (m_cnt == B) m_owner = -1;
            end
        end
    end

    // Per-cycle comparison against the model plus structural properties
    logic [3:0] prev_grant = 4'b0000;
    int         burst_words = 0;
    always @(negedge wclk) begin : cmp_p
        logic [3:0]   eg;
        logic [3:0]   ea;
        logic         es;
        logic [W-1:0] ed;
        int           gi;
        if (chk_en) begin
            eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
            es = (m_owner >= 0) && req_v[m_owner] && !full_v;
            ed = (m_owner < 0) ? '0 : rdata[m_owner];
            ea = es ? eg : 4'b0000;
            chk("grant", 32'(bus.grant), 32'(eg));
            chk("signal_write", 32'(bus.signal_write), 32'(es));
            chk("write_data", 32'(bus.write_data), 32'(ed));
            chk("ack", 32'(bus.ack), 32'(ea));
            chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
            chk("ack_onehot0", 32'($onehot0(bus.ack)), 32'd1);
            chk("write_while_full", 32'(bus.signal_write & full_v), 32'd0);
            for (int i = 0; i < 4; i++) if (bus.ack[i]) ackcnt[i]++;
            if (prev_grant == 4'b0000 && bus.grant != 4'b0000) begin
                burst_words = 0;
                gi = 0;
                for (int i = 0; i < 4; i++) if (bus.grant[i]) gi = i;
                for (int i = 0; i < 4; i++) begin
                    if (i != gi && req_at_edge[i]) begin
                        waits[i]++;
                        chk("fair_wait", 32'(waits[i] <= 3), 32'd1);
                    end
                end
                waits[gi] = 0;
            end
            if (bus.signal_write) begin
                burst_words++;
                chk("burst_len", 32'(burst_words <= B), 32'd1);
            end
            prev_grant = bus.grant;
        end
    end

    task automatic step();
        @(posedge wclk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge wclk);
        #2;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_signal_write", 32'(bus.signal_write), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_write_data", 32'(bus.write_data), 32'd0);
        for (int i = 0; i < 4; i++) begin
            waits[i]  = 0;
            ackcnt[i] = 0;
        end
        rst = 1'b0;
    endtask

    logic [3:0] seq [$];
    logic [3:0] exp_seq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                4'b0000, 4'b1000, 4'b0000, 4'b0001};

    initial begin
        logic [3:0] prev;
        req_v  = 4'b0000;
        full_v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rdata[i]  = '0;
            waits[i]  = 0;
            ackcnt[i] = 0;
        end
        #1 rst = 1'b1;
        #2 chk_en = 1;
        rdata[1] = 8'h3C;
        do_reset();

        // Single requester, one full burst of a constant word
        rdata[0] = 8'hA5;
        req_v    = 4'b0001;
        step();
        chk("t1_grant_e1", 32'(bus.grant), 32'h1);
        chk("t1_sw_e1", 32'(bus.signal_write), 32'd1);
        chk("t1_wd_e1", 32'(bus.write_data), 32'hA5);
        chk("t1_ack_e1", 32'(bus.ack), 32'h1);
        repeat (3) step();
        chk("t1_grant_e4", 32'(bus.grant), 32'h1);
        step();
        chk("t1_grant_e5", 32'(bus.grant), 32'h0);
        req_v = 4'b0000;
        chk("t1_writes", 32'(ackcnt[0]), 32'd4);

        // All four requesting: full round-robin rotation
        do_reset();
        for (int i = 0; i < 4; i++) rdata[i] = W'(8'h10 + i);
        req_v = 4'b1111;
        prev  = 4'b0000;
        seq.delete();
        for (int e = 0; e < 21; e++) begin
            step();
            if (bus.grant != prev) seq.push_back(bus.grant);
            prev = bus.grant;
        end
        chk("t2_changes", 32'(seq.size()), 32'd9);
        for (int i = 0; i < 9 && i < seq.size(); i++) chk("t2_grant_seq", 32'(seq[i]), 32'(exp_seq[i]));
        for (int i = 0; i < 4; i++) chk("t2_writes", 32'(ackcnt[i]), 32'd4);
        req_v = 4'b0000;
        step();

        // Owner 1 stalls on full after its first write
        do_reset();
        req_v = 4'b0010;
        step();
        chk("t3_grant_e1", 32'(bus.grant), 32'h2);
        step();
        full_v = 1'b1;
        repeat (3) begin
            step();
            chk("t3_stall_sw", 32'(bus.signal_write), 32'd0);
            chk("t3_stall_grant", 32'(bus.grant), 32'h2);
        end
        full_v = 1'b0;
        step();
        chk("t3_grant_e6", 32'(bus.grant), 32'h2);
        repeat (2) step();
        chk("t3_grant_e8", 32'(bus.grant), 32'h0);
        req_v = 4'b0000;
        chk("t3_writes", 32'(ackcnt[1]), 32'd4);

        // Owner 2 withdraws after two writes; next search starts at 3
        do_reset();
        req_v = 4'b0100;
        step();
        chk("t4_grant_e1", 32'(bus.grant), 32'h4);
        repeat (2) step();
        req_v = 4'b0000;
        #1;
        chk("t4_withdraw_sw", 32'(bus.signal_write), 32'd0);
        step();
        chk("t4_idle", 32'(bus.grant), 32'h0);
        req_v = 4'b0101;
        step();
        chk("t4_next_grant", 32'(bus.grant), 32'h1);
        chk("t4_writes", 32'(ackcnt[2]), 32'd2);
        req_v = 4'b0000;
        step();

        // Asynchronous reset in the middle of owner 3's burst
        do_reset();
        rdata[3] = 8'h77;
        req_v = 4'b1000;
        step();
        chk("t5_grant_e1", 32'(bus.grant), 32'h8);
        step();
        #1 rst = 1'b1;
        #1;
        chk("t5_async_grant", 32'(bus.grant), 32'h0);
        chk("t5_async_sw", 32'(bus.signal_write), 32'd0);
        chk("t5_async_ack", 32'(bus.ack), 32'h0);
        chk("t5_async_wd", 32'(bus.write_data), 32'h0);
        #2 rst = 1'b0;
        req_v = 4'b1111;
        step();
        chk("t5_after_rst", 32'(bus.grant), 32'h1);
        req_v = 4'b0000;
        step();

        // Randomized traffic with data advancing on each ack
        do_reset();
        for (int i = 0; i < 4; i++) rdata[i] = W'($urandom);
        adv_en = 1;
        for (int c = 0; c < 10000; c++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if (adv_en && adv[i]) rdata[i] = rdata[i] + W'(1);
                if (req_v[i]) begin
                    if ($urandom_range(0, 9) == 0) req_v[i] = 1'b0;
                end else if ($urandom_range(0, 9) < 3) begin
                    req_v[i] = 1'b1;
                end
            end
            full_v = ($urandom_range(0, 3) == 0);
        end
        req_v  = 4'b0000;
        full_v = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
